router_src_arb: RTL and testbench
=================================

Name: router_src_arb

Overview:
- Packet-level input arbiter in front of the 1x3 router's single input port (datain/packet_valid/busy).
- Shares that port among NUM_SRC packet sources using round-robin arbitration.
- Grants whole packets: header, payload and parity are forwarded with no interleaving.
- Honours the router's busy back-pressure and discards packets addressed to the non-existent port 3.

Parameters:
NUM_SRC, 3, number of packet sources (2..8)
SRC_W, $clog2(NUM_SRC), width of grant_id

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
src_req  in  NUM_SRC  source i has a packet; held until its last byte is acked
src_data  in  8*NUM_SRC  byte stream of source i in bits [8i+7:8i]; advances after src_ack[i]
src_ack  out  NUM_SRC  combinational; source i's current byte is consumed this cycle
busy  in  1  router back-pressure
datain  out  8  registered byte to router
packet_valid  out  1  registered; high for header and payload, low for parity
grant_id  out  SRC_W  index of the source owning the port
active  out  1  a packet is in progress
drop_pulse  out  1  one cycle at end of a dropped packet
done_pulse  out  1  one cycle when a forwarded packet's parity is accepted

Behaviour:
- Reset (async, resetn=0): state IDLE, datain=0, packet_valid=0, src_ack=0, grant_id=0, active=0, both pulses 0. RR pointer = NUM_SRC-1, so source 0 wins first. Mid-packet reset abandons the packet silently.
- Acceptance rule: adv = ~busy. The router consumes the presented byte at any rising edge with adv=1. datain/packet_valid change only at such edges (or on reset).
- Header byte: [7:2] = payload_len (0..63), [1:0] = addr.
- Internal: 6-bit down-counter cnt; 8-bit parity accumulator par.
- IDLE:
  - If adv and any src_req: pick the winner round-robin, searching upward from pointer+1 and wrapping.
  - Assert src_ack[winner] that cycle. Latch grant_id; set active=1; par=header.
  - addr != 3: datain<=header, packet_valid<=1, cnt<=len. Next state is PLD, or PAR if len=0.
  - addr == 3: no output change; cnt<=len; go to DROP.
- PLD: on adv, ack the source, datain<=byte, par^=byte, cnt--. When cnt reaches 0 after the load, go to PAR.
- PAR: on adv, ack the source, datain<=source parity byte, packet_valid<=0, go to LAST.
- LAST: on adv (parity accepted), datain<=0, done_pulse=1, active=0, pointer<=grant_id, go to IDLE.
  - This gives a one-cycle minimum bubble between packets.
- DROP: ack one byte every cycle, ignoring busy.
  - Consumes len payload bytes plus 1 parity byte.
  - After the parity ack: drop_pulse=1, active=0, pointer<=grant_id, go to IDLE.
  - datain/packet_valid stay 0 throughout.
- src_req deassertion mid-packet is a protocol violation; the arbiter keeps acking per its count.
- src_ack is never asserted for more than one source, and never while busy=1 outside DROP.

Optional Feature:
- ROUTER_ARB_PARITY_GEN_EN defined:
  - Sources supply only header and payload.
  - In PAR, datain<=par (XOR of header and all payload bytes) with no src_ack.
  - DROP consumes len bytes only; a len=0 drop finishes in one cycle.
- Undefined: sources supply the parity byte; par is unused and the synthesiser may remove it.

Decomposition:
- Package router_pkg: typedef of the header fields (len[5:0], addr[1:0]); constant ADDR_INVALID=2'b11; localparams for state encoding (IDLE, PLD, PAR, LAST, DROP).
- Sub-module rr_arbiter (req vector, pointer -> one-hot grant plus index), combinational and reusable.
- FSM, counter and output registers stay in router_src_arb.

Test Plan:
- Source 0 only, header 8'h3D (len 15, addr 1), busy=0 -> exactly 17 bytes on datain in consecutive cycles; packet_valid high for 16 bytes; done_pulse one cycle after the parity byte is accepted.
- src_req=3'b111 continuously, each source sending len=2 -> grant_id sequence 0,1,2,0; no interleaving; one idle cycle between packets.
- busy forced high for 3 cycles mid-payload -> datain held stable; no src_ack during the stall; byte order and count unchanged.
- Header 8'h01 (len 0, addr 1) -> header then parity only; with ROUTER_ARB_PARITY_GEN_EN the parity equals 8'h01.
- Header 8'h0F (len 3, addr 3) -> 4 acks in 4 cycles, even with busy=1; packet_valid stays 0; drop_pulse once; next requester is then granted.
- resetn pulsed low in PLD -> all outputs 0 immediately; a request after release starts at source 0 with a fresh header.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router input arbiter.
// Optional build macro used by router_src_arb: ROUTER_ARB_PARITY_GEN_EN.
package router_pkg;

    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } hdr_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLD  = 3'd1;
    localparam logic [2:0] ST_PAR  = 3'd2;
    localparam logic [2:0] ST_LAST = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PLD  = ST_PLD,
        S_PAR  = ST_PAR,
        S_LAST = ST_LAST,
        S_DROP = ST_DROP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from i_ptr+1 with wrap,
// returning a one-hot grant and the winning index.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
                o_any                            = 1'b1;
                o_grant[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                            = W'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/router_src_arb.sv
// Packet-level round-robin arbiter sharing the router input port among NUM_SRC sources.
// Define ROUTER_ARB_PARITY_GEN_EN to generate the parity byte here instead of taking it from the source.
//
// state | meaning
// IDLE  | no packet owned; grant on adv when any source requests
// PLD   | forwarding payload bytes, cnt holds bytes still to send
// PAR   | next accepted slot carries the parity byte
// LAST  | parity is on datain, waiting for the router to take it
// DROP  | swallowing a packet addressed to port 3, one byte per cycle
module router_src_arb
    import router_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ack,
    input  logic                 busy,
    output logic [7:0]           datain,
    output logic                 packet_valid,
    output logic [SRC_W-1:0]     grant_id,
    output logic                 active,
    output logic                 drop_pulse,
    output logic                 done_pulse
);

    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

    state_t             r_state, w_state_nxt;
    logic [5:0]         r_cnt, w_cnt_nxt;
    logic [7:0]         r_par, w_par_nxt;
    logic [7:0]         r_datain, w_datain_nxt;
    logic               r_pv, w_pv_nxt;
    logic [SRC_W-1:0]   r_grant, w_grant_nxt;
    logic [SRC_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_active, w_active_nxt;
    logic               r_drop, w_drop_nxt;
    logic               r_done, w_done_nxt;

    logic               w_adv;
    logic [NUM_SRC-1:0] w_win_grant;
    logic [SRC_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic [SRC_W-1:0]   w_sel;
    logic [7:0]         w_byte;
    hdr_t               w_hdr;
    logic [NUM_SRC-1:0] w_cur_oh;
    logic [NUM_SRC-1:0] w_ack;

    rr_arbiter #(.N(NUM_SRC), .W(SRC_W)) u_rr (
        .i_req   (src_req),
        .i_ptr   (r_ptr),
        .o_grant (w_win_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_win_any)
    );

    assign w_adv    = ~busy;
    assign w_sel    = (r_state == S_IDLE) ? w_win_idx : r_grant;
    assign w_cur_oh = ONE_HOT0 << r_grant;
    assign w_hdr    = w_byte;

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_sel == SRC_W'(i)) w_byte = src_data[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_par_nxt    = r_par;
        w_datain_nxt = r_datain;
        w_pv_nxt     = r_pv;
        w_grant_nxt  = r_grant;
        w_ptr_nxt    = r_ptr;
        w_active_nxt = r_active;
        w_drop_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_ack        = '0;
        case (r_state)
            S_IDLE: begin
                if (w_adv && w_win_any) begin
                    w_ack        = w_win_grant;
                    w_grant_nxt  = w_win_idx;
                    w_active_nxt = 1'b1;
                    w_par_nxt    = w_byte;
                    w_cnt_nxt    = w_hdr.len;
                    if (w_hdr.addr == ADDR_INVALID) begin
                        w_state_nxt = S_DROP;
                    end else begin
                        w_datain_nxt = w_byte;
                        w_pv_nxt     = 1'b1;
                        w_state_nxt  = (w_hdr.len == 6'd0) ? S_PAR : S_PLD;
                    end
                end
            end
            S_PLD: begin
                if (w_adv) begin
                    w_ack        = w_cur_oh;
                    w_datain_nxt = w_byte;
                    w_par_nxt    = r_par ^ w_byte;
                    w_cnt_nxt    = r_cnt - 6'd1;
                    if (r_cnt == 6'd1) w_state_nxt = S_PAR;
                end
            end
            S_PAR: begin
                if (w_adv) begin
`ifdef ROUTER_ARB_PARITY_GEN_EN
                    w_datain_nxt = r_par;
`else
                    w_ack        = w_cur_oh;
                    w_datain_nxt = w_byte;
`endif
                    w_pv_nxt     = 1'b0;
                    w_state_nxt  = S_LAST;
                end
            end
            S_LAST: begin
                if (w_adv) begin
                    w_datain_nxt = 8'h00;
                    w_done_nxt   = 1'b1;
                    w_active_nxt = 1'b0;
                    w_ptr_nxt    = r_grant;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_DROP: begin
                // Drop ignores busy: nothing reaches the router, so there is no back-pressure to honour.
`ifdef ROUTER_ARB_PARITY_GEN_EN
                if (r_cnt != 6'd0) w_ack = w_cur_oh;
                if (r_cnt <= 6'd1) begin
`else
                w_ack = w_cur_oh;
                if (r_cnt == 6'd0) begin
`endif
                    w_drop_nxt   = 1'b1;
                    w_active_nxt = 1'b0;
                    w_ptr_nxt    = r_grant;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_par    <= '0;
            r_datain <= '0;
            r_pv     <= 1'b0;
            r_grant  <= '0;
            r_ptr    <= SRC_W'(NUM_SRC - 1);
            r_active <= 1'b0;
            r_drop   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_par    <= w_par_nxt;
            r_datain <= w_datain_nxt;
            r_pv     <= w_pv_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_active <= w_active_nxt;
            r_drop   <= w_drop_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign src_ack      = w_ack;
    assign datain       = r_datain;
    assign packet_valid = r_pv;
    assign grant_id     = r_grant;
    assign active       = r_active;
    assign drop_pulse   = r_drop;
    assign done_pulse   = r_done;

endmodule

// File: tb/tb_router_src_arb.sv
// Directed self-checking bench for router_src_arb (default build, sources supply parity).
module tb_router_src_arb;

    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            busy = 1'b0;
    logic [NS-1:0]   src_req;
    logic [NS-1:0]   src_ack;
    logic [8*NS-1:0] src_data;
    logic [7:0]      datain;
    logic            packet_valid;
    logic [1:0]      grant_id;
    logic            active, drop_pulse, done_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [NS][256];
    int         tot [NS] = '{default: 0};
    int         pos [NS] = '{default: 0};

    logic [7:0] exp_q[$];
    logic [7:0] rx[$];
    int         rxc[$];
    int         hcyc[$];
    logic [1:0] gids[$];
    int cyc = 0, pvn = 0, done_cnt = 0, drop_cnt = 0, done_cyc = 0;
    int viol = 0, stall_acks = 0;
    bit chk_stall = 1'b0;
    bit last_pv = 1'b0;

    always #5 clk = ~clk;

    router_src_arb #(.NUM_SRC(NS)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .src_req      (src_req),
        .src_data     (src_data),
        .src_ack      (src_ack),
        .busy         (busy),
        .datain       (datain),
        .packet_valid (packet_valid),
        .grant_id     (grant_id),
        .active       (active),
        .drop_pulse   (drop_pulse),
        .done_pulse   (done_pulse)
    );

    // Source model: byte stream per source, advanced by src_ack.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            src_req[i]         = pos[i] < tot[i];
            src_data[8*i +: 8] = mem[i][pos[i] % 256];
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NS; i++) pos[i] <= tot[i];
        end else begin
            for (int i = 0; i < NS; i++) if (src_ack[i]) pos[i] <= pos[i] + 1;
        end
    end

    // Router-side monitor: records every byte the router accepts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ($countones(src_ack) > 1) viol++;
        if (chk_stall && busy && (src_ack != '0)) stall_acks++;
        if (!resetn) begin
            last_pv = 1'b0;
        end else if (!busy) begin
            if (packet_valid) begin
                if (!last_pv) begin
                    gids.push_back(grant_id);
                    hcyc.push_back(cyc);
                end
                rx.push_back(datain);
                rxc.push_back(cyc);
                pvn++;
                last_pv = 1'b1;
            end else if (last_pv) begin
                rx.push_back(datain);
                rxc.push_back(cyc);
                last_pv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done_pulse) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (drop_pulse) drop_cnt++;
    end

    task automatic clear_logs();
        exp_q.delete(); rx.delete(); rxc.delete(); hcyc.delete(); gids.delete();
        pvn = 0; done_cnt = 0; drop_cnt = 0;
    endtask

    task automatic add_pkt(input int s, input logic [7:0] hdr, input logic [7:0] seed, input bit fwd);
        logic [7:0] p, b;
        int len;
        len = int'(hdr[7:2]);
        p = hdr;
        mem[s][tot[s]] = hdr; tot[s]++;
        if (fwd) exp_q.push_back(hdr);
        for (int k = 0; k < len; k++) begin
            b = seed + 8'(k);
            p ^= b;
            mem[s][tot[s]] = b; tot[s]++;
            if (fwd) exp_q.push_back(b);
        end
        mem[s][tot[s]] = p; tot[s]++;
        if (fwd) exp_q.push_back(p);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (src_req == '0 && !active) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_stream(input string name);
        n_cmp++;
        if (rx.size() !== exp_q.size()) begin
            $display("FAIL %s_len: got %0d bytes, want %0d", name, rx.size(), exp_q.size());
            n_err++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rx[i] !== exp_q[i]) begin
                    $display("FAIL %s_byte%0d: got %h, want %h", name, i, rx[i], exp_q[i]);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({datain, packet_valid, src_ack, grant_id, active, drop_pulse, done_pulse} !== '0) begin
            $display("FAIL reset_outputs: got d=%h pv=%b ack=%b g=%0d a=%b dp=%b dn=%b, want all 0",
                     datain, packet_valid, src_ack, grant_id, active, drop_pulse, done_pulse);
            n_err++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({active, packet_valid, src_ack} !== '0) begin
            $display("FAIL reset_idle: got a=%b pv=%b ack=%b, want 0", active, packet_valid, src_ack);
            n_err++;
        end
    endtask

    task automatic test_rr();
        bit ok;
        logic [1:0] want [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        clear_logs();
        add_pkt(0, 8'h08, 8'h10, 1);
        add_pkt(1, 8'h09, 8'h20, 1);
        add_pkt(2, 8'h0A, 8'h30, 1);
        add_pkt(0, 8'h08, 8'h50, 1);
        wait_idle(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL rr_timeout: got %b, want 1", ok); n_err++; end
        check_stream("rr");
        n_cmp++;
        if (gids.size() !== 4) begin
            $display("FAIL rr_npkt: got %0d, want 4", gids.size()); n_err++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (gids[i] !== want[i]) begin
                    $display("FAIL rr_grant%0d: got %0d, want %0d", i, gids[i], want[i]); n_err++;
                end
                if (i > 0) begin
                    n_cmp++;
                    if (hcyc[i] - hcyc[i-1] !== 5) begin
                        $display("FAIL rr_gap%0d: got %0d, want 5", i, hcyc[i] - hcyc[i-1]); n_err++;
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        add_pkt(0, 8'h3D, 8'hA0, 1);
        wait_idle(200, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL single_timeout: got %b, want 1", ok); n_err++; end
        check_stream("single");
        n_cmp++;
        if (pvn !== 16) begin $display("FAIL single_pv_count: got %0d, want 16", pvn); n_err++; end
        n_cmp++;
        if (done_cnt !== 1) begin $display("FAIL single_done_cnt: got %0d, want 1", done_cnt); n_err++; end
        if (rxc.size() == 17) begin
            n_cmp++;
            if (rxc[16] - rxc[0] !== 16) begin
                $display("FAIL single_consecutive: got span %0d, want 16", rxc[16] - rxc[0]); n_err++;
            end
            n_cmp++;
            if (done_cyc !== rxc[16] + 1) begin
                $display("FAIL single_done_time: got %0d, want %0d", done_cyc, rxc[16] + 1); n_err++;
            end
        end
    endtask

    task automatic test_busy_stall();
        bit ok;
        bit stable;
        int bad_ack;
        logic [7:0] d0;
        clear_logs();
        add_pkt(1, 8'h16, 8'h40, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx.size() >= 3) begin ok = 1'b1; break; end
        end
        busy = 1'b1;
        chk_stall = 1'b1;
        d0 = datain;
        stable = 1'b1;
        bad_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (datain !== d0) stable = 1'b0;
            if (src_ack !== '0) bad_ack++;
        end
        busy = 1'b0;
        chk_stall = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL stall_reach: got %b, want 1", ok); n_err++; end
        n_cmp++;
        if (d0 !== 8'h42) begin $display("FAIL stall_byte: got %h, want 42", d0); n_err++; end
        n_cmp++;
        if (stable !== 1'b1) begin $display("FAIL stall_stable: got %b, want 1", stable); n_err++; end
        n_cmp++;
        if (bad_ack !== 0 || stall_acks !== 0) begin
            $display("FAIL stall_ack: got %0d/%0d acks, want 0", bad_ack, stall_acks); n_err++;
        end
        wait_idle(100, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL stall_timeout: got %b, want 1", ok); n_err++; end
        check_stream("stall");
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_logs();
        add_pkt(2, 8'h01, 8'h00, 1);
        wait_idle(50, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL zlen_timeout: got %b, want 1", ok); n_err++; end
        n_cmp++;
        if (rx.size() !== 2 || rx[0] !== 8'h01 || rx[1] !== 8'h01) begin
            $display("FAIL zlen_stream: got %0d bytes first %h, want 2 bytes 01 01", rx.size(), rx.size() > 0 ? rx[0] : 8'h00);
            n_err++;
        end
        n_cmp++;
        if (pvn !== 1) begin $display("FAIL zlen_pv_count: got %0d, want 1", pvn); n_err++; end
    endtask

    task automatic test_drop();
        bit ok;
        int ack_ok;
        bit pv_seen;
        clear_logs();
        add_pkt(0, 8'h0F, 8'h60, 0);
        add_pkt(1, 8'h05, 8'h70, 1);
        @(negedge clk);
        n_cmp++;
        if (active !== 1'b1 || packet_valid !== 1'b0 || datain !== 8'h00) begin
            $display("FAIL drop_enter: got a=%b pv=%b d=%h, want 1 0 00", active, packet_valid, datain); n_err++;
        end
        busy = 1'b1;
        ack_ok = 0;
        pv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (src_ack === 3'b001) ack_ok++;
            if (packet_valid) pv_seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (ack_ok !== 4) begin $display("FAIL drop_acks: got %0d, want 4", ack_ok); n_err++; end
        n_cmp++;
        if (pv_seen !== 1'b0) begin $display("FAIL drop_pv: got %b, want 0", pv_seen); n_err++; end
        n_cmp++;
        if (drop_pulse !== 1'b1 || active !== 1'b0 || src_ack !== 3'b000) begin
            $display("FAIL drop_end: got dp=%b a=%b ack=%b, want 1 0 000", drop_pulse, active, src_ack); n_err++;
        end
        busy = 1'b0;
        wait_idle(50, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL drop_timeout: got %b, want 1", ok); n_err++; end
        n_cmp++;
        if (drop_cnt !== 1) begin $display("FAIL drop_cnt: got %0d, want 1", drop_cnt); n_err++; end
        n_cmp++;
        if (gids.size() !== 1 || gids[0] !== 2'd1) begin
            $display("FAIL drop_next_grant: got n=%0d g=%0d, want n=1 g=1", gids.size(), gids.size() > 0 ? gids[0] : 2'd0);
            n_err++;
        end
        check_stream("drop_next");
    endtask

    task automatic test_mid_reset();
        bit ok;
        clear_logs();
        add_pkt(1, 8'h28, 8'h80, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx.size() >= 3) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL mreset_reach: got %b, want 1", ok); n_err++; end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({datain, packet_valid, active, grant_id, src_ack, done_pulse, drop_pulse} !== '0) begin
            $display("FAIL mreset_outputs: got d=%h pv=%b a=%b g=%0d ack=%b, want all 0",
                     datain, packet_valid, active, grant_id, src_ack);
            n_err++;
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        add_pkt(0, 8'h05, 8'h90, 1);
        add_pkt(1, 8'h06, 8'hA0, 1);
        add_pkt(2, 8'h05, 8'hB0, 1);
        wait_idle(100, ok);
        n_cmp++;
        if (ok !== 1'b1) begin $display("FAIL mreset_timeout: got %b, want 1", ok); n_err++; end
        n_cmp++;
        if (gids.size() !== 3 || gids[0] !== 2'd0 || gids[1] !== 2'd1 || gids[2] !== 2'd2) begin
            $display("FAIL mreset_order: got n=%0d first=%0d, want 0,1,2", gids.size(), gids.size() > 0 ? gids[0] : 2'd3);
            n_err++;
        end
        check_stream("mreset");
    endtask

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_busy_stall();
        test_zero_len();
        test_drop();
        test_mid_reset();
        n_cmp++;
        if (viol !== 0) begin $display("FAIL ack_onehot: got %0d violations, want 0", viol); n_err++; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
